// File: rtl/scm_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// scm_wr_burst_ctrl
// Write-side sequencer for the latch-based 1W/multi-read SCM. Accepts a burst
// command (first word address + beat count) and a valid/ready stream of beats,
// and issues one registered write per accepted beat with an incrementing
// (wrapping) word address. done_o is raised only once the last word has had
// its latch-open cycle, so it is readable when done_o is seen.
//
// Optional feature macro: SCM_WR_ALIGN_CHECK_EN
//   defined   : commands with odd address or odd length are handshaken but
//               rejected with a one-cycle err_o pulse (no writes, no done_o).
//   undefined : no alignment check, err_o stays 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o       burst command handshake
//   cmd_addr_i, cmd_len_i         first word address, beat count (0 = no-op)
//   data_valid_i/data_ready_o     write beat handshake
//   data_i                        write beat payload
//   WriteEnable/WriteAddr/WriteData  registered SCM write port
//   busy_o                        FSM not in IDLE
//   done_o                        one-cycle burst-complete pulse
//   err_o                         one-cycle command-rejected pulse
//
// State | meaning
// IDLE  | waiting for a command; data stream not accepted
// BURST | accepting beats, one SCM write per accepted beat
// SETTLE| last beat's write is on the SCM port; done_o follows
// -----------------------------------------------------------------------------
module scm_wr_burst_ctrl #(
    parameter int WADDR_WIDTH = 5,
    parameter int WDATA_WIDTH = 64,
    parameter int LEN_WIDTH   = WADDR_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [WADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]   cmd_len_i,
    input  logic                   data_valid_i,
    output logic                   data_ready_o,
    input  logic [WDATA_WIDTH-1:0] data_i,
    output logic                   WriteEnable,
    output logic [WADDR_WIDTH-1:0] WriteAddr,
    output logic [WDATA_WIDTH-1:0] WriteData,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]   r_rem;
    logic                   r_we;
    logic [WADDR_WIDTH-1:0] r_waddr;
    logic [WDATA_WIDTH-1:0] r_wdata;
    logic                   r_done;
    logic                   r_err;

    logic                   w_cmd_hs;
    logic                   w_data_hs;
    logic                   w_cmd_bad;

    assign cmd_ready_o  = (r_state == IDLE);
    assign data_ready_o = (r_state == BURST);
    assign busy_o       = (r_state != IDLE);

    assign w_cmd_hs  = cmd_valid_i & cmd_ready_o;
    assign w_data_hs = data_valid_i & data_ready_o;

`ifdef SCM_WR_ALIGN_CHECK_EN
    // 128-bit read port: a burst must cover whole even/odd word pairs.
    assign w_cmd_bad = cmd_addr_i[0] | cmd_len_i[0];
`else
    assign w_cmd_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Pulses and write enable default low; address/data hold.
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        if (w_cmd_bad) begin
                            r_err <= 1'b1;
                        end else if (cmd_len_i == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr  <= cmd_addr_i;
                            r_rem   <= cmd_len_i;
                            r_state <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (w_data_hs) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= data_i;
                        r_addr  <= r_addr + WADDR_WIDTH'(1);
                        r_rem   <= r_rem - LEN_WIDTH'(1);
                        if (r_rem == LEN_WIDTH'(1)) begin
                            r_state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    // SCM captures the last word at the end of this cycle and
                    // its latch is transparent next cycle, alongside done_o.
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign WriteEnable = r_we;
    assign WriteAddr   = r_waddr;
    assign WriteData   = r_wdata;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: doc/scm_wr_burst_ctrl.md
Name: scm_wr_burst_ctrl

Overview:
Write-side sequencer for the latch-based 1W/multi-read SCM (64b write port, 128b read port). Accepts a burst command (base word address and beat count) plus a valid/ready stream of 64-bit beats. Drives the SCM write port with one registered WriteEnable/WriteAddr/WriteData per accepted beat, incrementing the word address each beat. Signals completion only once the final word is readable through the SCM latches.

Parameters:
WADDR_WIDTH, 5, SCM word address width; the SCM holds 2^WADDR_WIDTH 64-bit words.
WDATA_WIDTH, 64, beat / SCM write data width.
LEN_WIDTH, WADDR_WIDTH+1, width of the burst beat count.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid_i  in  1  burst command valid
cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
cmd_addr_i  in  WADDR_WIDTH  first word address of the burst
cmd_len_i  in  LEN_WIDTH  number of 64-bit beats; 0 = no-op
data_valid_i  in  1  write beat valid
data_ready_o  out  1  write beat accepted when high together with data_valid_i
data_i  in  WDATA_WIDTH  write beat payload
WriteEnable  out  1  SCM write enable
WriteAddr  out  WADDR_WIDTH  SCM write word address
WriteData  out  WDATA_WIDTH  SCM write data
busy_o  out  1  high whenever the FSM is not in IDLE
done_o  out  1  one-cycle pulse: burst complete, all words readable
err_o  out  1  one-cycle pulse: command rejected (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (synchronous, sampled at posedge clk):
  - FSM goes to IDLE; the address counter and the remaining-beat counter clear to 0.
  - Outputs: WriteEnable=0, WriteAddr=0, WriteData=0, done_o=0, err_o=0, busy_o=0.
  - In IDLE after reset, cmd_ready_o=1 and data_ready_o=0.
- FSM states: IDLE, BURST, SETTLE.
- IDLE:
  - cmd_ready_o=1, data_ready_o=0.
  - On cmd handshake with len>0: latch addr and len, go to BURST.
  - On cmd handshake with len==0: stay in IDLE and pulse done_o in the next cycle.
  - data_valid_i is ignored.
- BURST:
  - cmd_ready_o=0, data_ready_o=1.
  - Each data handshake in cycle t: in cycle t+1, WriteEnable=1, WriteAddr = current address, WriteData = data_i. Address increments by 1 and the remaining-beat count decrements by 1.
  - Cycles without a handshake (bubbles) give WriteEnable=0 in the following cycle. WriteAddr and WriteData hold their last values.
  - The handshake that takes the remaining count to 0 moves the FSM to SETTLE.
- Address arithmetic: modulo 2^WADDR_WIDTH, so 2^WADDR_WIDTH-1 wraps to 0. A len greater than 2^WADDR_WIDTH wraps and overwrites earlier words. This is legal, not an error.
- SETTLE:
  - Lasts one cycle; cmd_ready_o=0, data_ready_o=0.
  - The last beat's WriteEnable is high in this cycle. The SCM samples the data at the end of this cycle and its latch opens during the next cycle.
  - Then go to IDLE with done_o=1 for exactly one cycle. If the last beat is handshaken in cycle t, done_o is high in cycle t+2.
- Back-to-back: a new command may be accepted in the same cycle done_o is high, since the FSM is already in IDLE.
- Reset mid-burst: the partial burst is abandoned. No done_o and no further writes follow. Words already written stay in the SCM.
- busy_o is combinational from state: high in BURST and SETTLE.
- WriteEnable is never high for two writes to the same address in consecutive cycles unless the burst wrapped.

Optional Feature:
SCM_WR_ALIGN_CHECK_EN
- Defined:
  - Commands must be 128-bit aligned: cmd_addr_i[0]==0 and cmd_len_i[0]==0.
  - A misaligned command is still handshaken (cmd_ready_o=1). err_o pulses in the next cycle, the FSM stays in IDLE, no writes are issued and no done_o follows.
  - A zero-length aligned command behaves as the normal no-op.
- Undefined: no alignment check is performed and err_o is tied to 0.

Test Plan:
1. Reset, then cmd addr=4 len=2 with two back-to-back beats 0xA.., 0xB.. -> WriteEnable high 2 consecutive cycles, WriteAddr 4 then 5, done_o exactly 2 cycles after the second handshake, busy_o low in the done cycle.
2. cmd addr=30 len=4 (WADDR_WIDTH=5) -> WriteAddr sequence 30, 31, 0, 1; single done_o pulse.
3. Beats with data_valid_i toggling 1,0,1,0 for len=2 -> WriteEnable follows 1,0,1; no write during bubbles; done_o 2 cycles after the last beat.
4. cmd len=0 -> no WriteEnable, done_o one cycle after the handshake; data_valid_i asserted in IDLE is never accepted (data_ready_o=0).
5. rst asserted after the 1st of 3 beats -> next cycle all outputs 0 and FSM in IDLE, no done_o; a following cmd addr=0 len=1 completes normally.
6. With SCM_WR_ALIGN_CHECK_EN: cmd addr=3 len=2 -> err_o pulse, no WriteEnable; cmd addr=2 len=2 -> normal completion, err_o=0.
